// File: rtl/mul_add_seq.sv
// Sequential unsigned multiply-add, P = X*Y + Z, retiring one multiplier bit per clock.
// Pairs with the restoring divider to rebuild a dividend from quotient, divisor and remainder.
module mul_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    input  logic [WIDTH-1:0]   Z,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               ok,
    output logic               done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic                 w_load;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_accSum;

    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_busy;
    logic                 r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // start is only honoured outside RUN; the last iteration is the one seen with cnt==0
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_last      = 1'b1;
                    w_stateNext = DONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // The sum cannot exceed 2^(2W) - 2^W, so the carry out is dropped safely
    assign w_accSum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else if (w_load) begin
            r_acc    <= {{WIDTH{1'b0}}, Z};
            r_mcand  <= {{WIDTH{1'b0}}, X};
            r_mplier <= Y;
            r_cnt    <= CNT_W'(WIDTH - 1);
        end else if (r_state == RUN) begin
            r_acc    <= w_accSum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_p <= w_accSum;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Status flags are registered so no input reaches an output combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_stateNext == RUN);
            r_done <= w_last;
        end
    end

    assign P    = r_p;
    assign busy = r_busy;
    assign ok   = ~r_busy;
    assign done = r_done;

endmodule
